// File: rtl/hdmi_timing_pkg.sv
// Shared types and presets for the HDMI video timing generator.
package hdmi_timing_pkg;

  localparam int unsigned TIMING_W = 12;

  typedef struct packed {
    logic [TIMING_W-1:0] active;
    logic [TIMING_W-1:0] fp;
    logic [TIMING_W-1:0] sync;
    logic [TIMING_W-1:0] bp;
  } timing_t;

  typedef enum logic [1:0] {
    MODE_480P  = 2'd0,
    MODE_720P  = 2'd1,
    MODE_1080P = 2'd2
  } mode_e;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } pol_e;

  function automatic timing_t h_preset(input mode_e mode);
    case (mode)
      MODE_480P:  h_preset = '{active: 12'd640,  fp: 12'd16,  sync: 12'd96, bp: 12'd48};
      MODE_1080P: h_preset = '{active: 12'd1920, fp: 12'd88,  sync: 12'd44, bp: 12'd148};
      default:    h_preset = '{active: 12'd1280, fp: 12'd110, sync: 12'd40, bp: 12'd220};
    endcase
  endfunction

  function automatic timing_t v_preset(input mode_e mode);
    case (mode)
      MODE_480P:  v_preset = '{active: 12'd480,  fp: 12'd10, sync: 12'd2, bp: 12'd33};
      MODE_1080P: v_preset = '{active: 12'd1080, fp: 12'd4,  sync: 12'd5, bp: 12'd36};
      default:    v_preset = '{active: 12'd720,  fp: 12'd5,  sync: 12'd5, bp: 12'd20};
    endcase
  endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One timing axis: wrapping position counter plus active and sync window decodes.
module hdmi_timing_axis #(
  parameter int unsigned W    = 12,
  parameter int unsigned INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] active,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  input  logic [W-1:0] total,
  output logic [W-1:0] cnt,
  output logic         wrap_c,
  output logic         active_c,
  output logic         sync_c
);

  localparam logic [W-1:0] INIT_W = W'(INIT);

  logic [W-1:0] sync_lo;
  logic [W-1:0] sync_hi;

  assign sync_lo  = active + fp;
  assign sync_hi  = sync_lo + sync;
  assign wrap_c   = (cnt == total - W'(1));
  assign active_c = (cnt < active);
  assign sync_c   = (cnt >= sync_lo) && (cnt < sync_hi);

  // Load re-seeds the counter when new timing takes effect.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= INIT_W;
    end else if (step) begin
      cnt <= wrap_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Runtime-reprogrammable video timing generator with frame-boundary config apply.
// Optional pix_req prefetch output when HDMI_TIMING_PREFETCH_EN is defined.
module hdmi_timing_gen
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_WIDTH = 12,
  parameter int unsigned V_WIDTH = 12,
  parameter int unsigned DEF_HA  = 32'(h_preset(MODE_720P).active),
  parameter int unsigned DEF_HFP = 32'(h_preset(MODE_720P).fp),
  parameter int unsigned DEF_HS  = 32'(h_preset(MODE_720P).sync),
  parameter int unsigned DEF_HBP = 32'(h_preset(MODE_720P).bp),
  parameter int unsigned DEF_VA  = 32'(v_preset(MODE_720P).active),
  parameter int unsigned DEF_VFP = 32'(v_preset(MODE_720P).fp),
  parameter int unsigned DEF_VS  = 32'(v_preset(MODE_720P).sync),
  parameter int unsigned DEF_VBP = 32'(v_preset(MODE_720P).bp),
  parameter logic        HS_POL  = POL_HIGH,
  parameter logic        VS_POL  = POL_HIGH
`ifdef HDMI_TIMING_PREFETCH_EN
  ,parameter int unsigned PREFETCH = 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [H_WIDTH-1:0] cfg_h_active,
  input  logic [H_WIDTH-1:0] cfg_h_fp,
  input  logic [H_WIDTH-1:0] cfg_h_sync,
  input  logic [H_WIDTH-1:0] cfg_h_bp,
  input  logic [V_WIDTH-1:0] cfg_v_active,
  input  logic [V_WIDTH-1:0] cfg_v_fp,
  input  logic [V_WIDTH-1:0] cfg_v_sync,
  input  logic [V_WIDTH-1:0] cfg_v_bp,
  input  logic               cfg_load,
  output logic               cfg_busy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [H_WIDTH-1:0] x,
  output logic [V_WIDTH-1:0] y,
  output logic               line_start,
  output logic               frame_start
`ifdef HDMI_TIMING_PREFETCH_EN
  ,output logic              pix_req
`endif
);

  localparam logic [H_WIDTH-1:0] DEF_HA_W  = H_WIDTH'(DEF_HA);
  localparam logic [H_WIDTH-1:0] DEF_HFP_W = H_WIDTH'(DEF_HFP);
  localparam logic [H_WIDTH-1:0] DEF_HS_W  = H_WIDTH'(DEF_HS);
  localparam logic [H_WIDTH-1:0] DEF_HT_W  = H_WIDTH'(DEF_HA + DEF_HFP + DEF_HS + DEF_HBP);
  localparam logic [V_WIDTH-1:0] DEF_VA_W  = V_WIDTH'(DEF_VA);
  localparam logic [V_WIDTH-1:0] DEF_VFP_W = V_WIDTH'(DEF_VFP);
  localparam logic [V_WIDTH-1:0] DEF_VS_W  = V_WIDTH'(DEF_VS);
  localparam logic [V_WIDTH-1:0] DEF_VT_W  = V_WIDTH'(DEF_VA + DEF_VFP + DEF_VS + DEF_VBP);

  logic [H_WIDTH-1:0] h_active, h_fp, h_sync, h_total;
  logic [V_WIDTH-1:0] v_active, v_fp, v_sync, v_total;
  logic [H_WIDTH-1:0] pend_h_active, pend_h_fp, pend_h_sync, pend_h_bp;
  logic [V_WIDTH-1:0] pend_v_active, pend_v_fp, pend_v_sync, pend_v_bp;

  logic [H_WIDTH-1:0] h_cnt;
  logic [V_WIDTH-1:0] v_cnt;
  logic h_wrap_c, h_active_c, h_sync_c;
  logic v_wrap_c, v_active_c, v_sync_c;
  logic apply_c;

  assign apply_c = en && h_wrap_c && v_wrap_c && cfg_busy;

  hdmi_timing_axis #(.W(H_WIDTH), .INIT(0)) u_h_axis (
    .clk(clk), .rst(rst), .step(en), .load(1'b0),
    .active(h_active), .fp(h_fp), .sync(h_sync), .total(h_total),
    .cnt(h_cnt), .wrap_c(h_wrap_c), .active_c(h_active_c), .sync_c(h_sync_c)
  );

  hdmi_timing_axis #(.W(V_WIDTH), .INIT(0)) u_v_axis (
    .clk(clk), .rst(rst), .step(en && h_wrap_c), .load(1'b0),
    .active(v_active), .fp(v_fp), .sync(v_sync), .total(v_total),
    .cnt(v_cnt), .wrap_c(v_wrap_c), .active_c(v_active_c), .sync_c(v_sync_c)
  );

  // Pending set is promoted on the last pixel of a frame; a load in that cycle stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_active      <= DEF_HA_W;
      h_fp          <= DEF_HFP_W;
      h_sync        <= DEF_HS_W;
      h_total       <= DEF_HT_W;
      v_active      <= DEF_VA_W;
      v_fp          <= DEF_VFP_W;
      v_sync        <= DEF_VS_W;
      v_total       <= DEF_VT_W;
      pend_h_active <= '0;
      pend_h_fp     <= '0;
      pend_h_sync   <= '0;
      pend_h_bp     <= '0;
      pend_v_active <= '0;
      pend_v_fp     <= '0;
      pend_v_sync   <= '0;
      pend_v_bp     <= '0;
      cfg_busy      <= 1'b0;
    end else begin
      if (apply_c) begin
        h_active <= pend_h_active;
        h_fp     <= pend_h_fp;
        h_sync   <= pend_h_sync;
        h_total  <= pend_h_active + pend_h_fp + pend_h_sync + pend_h_bp;
        v_active <= pend_v_active;
        v_fp     <= pend_v_fp;
        v_sync   <= pend_v_sync;
        v_total  <= pend_v_active + pend_v_fp + pend_v_sync + pend_v_bp;
      end
      if (cfg_load) begin
        pend_h_active <= cfg_h_active;
        pend_h_fp     <= cfg_h_fp;
        pend_h_sync   <= cfg_h_sync;
        pend_h_bp     <= cfg_h_bp;
        pend_v_active <= cfg_v_active;
        pend_v_fp     <= cfg_v_fp;
        pend_v_sync   <= cfg_v_sync;
        pend_v_bp     <= cfg_v_bp;
      end
      cfg_busy <= cfg_load || (cfg_busy && !apply_c);
    end
  end

  // Registered decode of the current position; syncs and coordinates hold while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= en && h_active_c && v_active_c;
      line_start  <= en && (h_cnt == '0) && v_active_c;
      frame_start <= en && (h_cnt == '0) && (v_cnt == '0);
      if (en) begin
        hsync <= h_sync_c ? HS_POL : ~HS_POL;
        vsync <= v_sync_c ? VS_POL : ~VS_POL;
        x     <= h_cnt;
        y     <= v_cnt;
      end
    end
  end

`ifdef HDMI_TIMING_PREFETCH_EN
  logic [H_WIDTH-1:0] unused_lead_h_cnt;
  logic [V_WIDTH-1:0] unused_lead_v_cnt;
  logic lead_h_wrap_c, lead_h_active_c, lead_v_active_c;
  logic unused_lead_h_sync, unused_lead_v_wrap, unused_lead_v_sync;

  // Lead position is re-seeded PREFETCH pixels into the new frame whenever timing is applied.
  hdmi_timing_axis #(.W(H_WIDTH), .INIT(PREFETCH)) u_lead_h_axis (
    .clk(clk), .rst(rst), .step(en), .load(apply_c),
    .active(h_active), .fp(h_fp), .sync(h_sync), .total(h_total),
    .cnt(unused_lead_h_cnt), .wrap_c(lead_h_wrap_c), .active_c(lead_h_active_c),
    .sync_c(unused_lead_h_sync)
  );

  hdmi_timing_axis #(.W(V_WIDTH), .INIT(0)) u_lead_v_axis (
    .clk(clk), .rst(rst), .step(en && lead_h_wrap_c), .load(apply_c),
    .active(v_active), .fp(v_fp), .sync(v_sync), .total(v_total),
    .cnt(unused_lead_v_cnt), .wrap_c(unused_lead_v_wrap), .active_c(lead_v_active_c),
    .sync_c(unused_lead_v_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_req <= 1'b0;
    end else begin
      pix_req <= en && lead_h_active_c && lead_v_active_c;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed self-checking bench for hdmi_timing_gen using a small default mode.
module tb_hdmi_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [11:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic        cfg_load;
  logic        cfg_busy, hsync, vsync, de, line_start, frame_start;
  logic [11:0] x, y;
`ifdef HDMI_TIMING_PREFETCH_EN
  logic        pix_req;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_err, n_de, n_hs, n_vs, n_ls, n_fs;
  int mh, mv;
  int frz_de, frz_sync;

  always #5 clk = ~clk;

  // Default mode: 35-cycle lines, 18-line frames; vsync active low.
  hdmi_timing_gen #(
    .H_WIDTH(12), .V_WIDTH(12),
    .DEF_HA(20), .DEF_HFP(4), .DEF_HS(6), .DEF_HBP(5),
    .DEF_VA(10), .DEF_VFP(2), .DEF_VS(3), .DEF_VBP(3),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_load(cfg_load), .cfg_busy(cfg_busy), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
`ifdef HDMI_TIMING_PREFETCH_EN
    ,.pix_req(pix_req)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    n_err = 0; n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
  endtask

  task automatic set_cfg(input int ha, hfp, hs, hbp, va, vfp, vs, vbp);
    cfg_h_active = 12'(ha); cfg_h_fp = 12'(hfp); cfg_h_sync = 12'(hs); cfg_h_bp = 12'(hbp);
    cfg_v_active = 12'(va); cfg_v_fp = 12'(vfp); cfg_v_sync = 12'(vs); cfg_v_bp = 12'(vbp);
  endtask

  // Advance n pixels with en=1, checking every output against the position model.
  task automatic run(input int n, input int ha, hfp, hs, hbp, va, vfp, vs, vbp);
    int ht, vt;
    logic e_de, e_hs, e_vs;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e_de = (mh < ha) && (mv < va);
      e_hs = (mh >= ha + hfp) && (mh < ha + hfp + hs);
      e_vs = (mv >= va + vfp) && (mv < va + vfp + vs);
      if (de !== e_de) n_err++;
      if (hsync !== e_hs) n_err++;
      if (vsync !== !e_vs) n_err++;
      if (e_de && (x !== 12'(mh) || y !== 12'(mv))) n_err++;
      if (line_start !== ((mh == 0) && (mv < va))) n_err++;
      if (frame_start !== ((mh == 0) && (mv == 0))) n_err++;
      if (de === 1'b1) n_de++;
      if (hsync === 1'b1) n_hs++;
      if (vsync === 1'b0) n_vs++;
      if (line_start === 1'b1) n_ls++;
      if (frame_start === 1'b1) n_fs++;
      mh++;
      if (mh == ht) begin
        mh = 0;
        mv++;
        if (mv == vt) mv = 0;
      end
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_de"}, 32'(de), 0);
    chk({pfx, "_hsync"}, 32'(hsync), 0);
    chk({pfx, "_vsync"}, 32'(vsync), 1);
    chk({pfx, "_x"}, 32'(x), 0);
    chk({pfx, "_y"}, 32'(y), 0);
    chk({pfx, "_line_start"}, 32'(line_start), 0);
    chk({pfx, "_frame_start"}, 32'(frame_start), 0);
    chk({pfx, "_busy"}, 32'(cfg_busy), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_state("reset");

    // Default mode, one full frame from reset release.
    rst = 1'b0; en = 1'b1; mh = 0; mv = 0;
    clear_tally();
    run(630, 20, 4, 6, 5, 10, 2, 3, 3);
    chk("def_model", 32'(n_err), 0);
    chk("def_de_count", 32'(n_de), 200);
    chk("def_hsync_count", 32'(n_hs), 108);
    chk("def_vsync_count", 32'(n_vs), 105);
    chk("def_line_starts", 32'(n_ls), 10);
    chk("def_frame_starts", 32'(n_fs), 1);

    // Mid-frame load of the 24x12 mode; applies after the last pixel of this frame.
    run(100, 20, 4, 6, 5, 10, 2, 3, 3);
    set_cfg(16, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b1;
    run(1, 20, 4, 6, 5, 10, 2, 3, 3);
    cfg_load = 1'b0;
    chk("busy_after_load", 32'(cfg_busy), 1);
    run(528, 20, 4, 6, 5, 10, 2, 3, 3);
    chk("busy_before_apply", 32'(cfg_busy), 1);
    run(1, 20, 4, 6, 5, 10, 2, 3, 3);
    chk("busy_at_apply", 32'(cfg_busy), 0);
    clear_tally();
    run(576, 16, 2, 4, 2, 8, 1, 2, 1);
    chk("a_model", 32'(n_err), 0);
    chk("a_de_count", 32'(n_de), 256);
    chk("a_hsync_count", 32'(n_hs), 96);
    chk("a_vsync_count", 32'(n_vs), 96);
    chk("a_line_starts", 32'(n_ls), 16);
    chk("a_frame_starts", 32'(n_fs), 2);

    // Load X mid-frame, then reload A in the apply cycle: X applies, A stays pending.
    run(100, 16, 2, 4, 2, 8, 1, 2, 1);
    set_cfg(12, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b1;
    run(1, 16, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b0;
    run(186, 16, 2, 4, 2, 8, 1, 2, 1);
    set_cfg(16, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b1;
    run(1, 16, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b0;
    chk("busy_load_in_apply", 32'(cfg_busy), 1);
    clear_tally();
    run(240, 12, 2, 4, 2, 8, 1, 2, 1);
    chk("x_model", 32'(n_err), 0);
    chk("x_de_count", 32'(n_de), 96);
    chk("x_frame_starts", 32'(n_fs), 1);
    chk("busy_second_apply", 32'(cfg_busy), 0);
    clear_tally();
    run(288, 16, 2, 4, 2, 8, 1, 2, 1);
    chk("a2_model", 32'(n_err), 0);
    chk("a2_de_count", 32'(n_de), 128);

    // Freeze for 10 cycles with the counter parked at (10,1).
    run(34, 16, 2, 4, 2, 8, 1, 2, 1);
    en = 1'b0;
    frz_de = 0; frz_sync = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (de !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) frz_de++;
      if (hsync !== 1'b0 || vsync !== 1'b1) frz_sync++;
    end
    chk("freeze_de_low", 32'(frz_de), 0);
    chk("freeze_sync_hold", 32'(frz_sync), 0);
    en = 1'b1;
    @(negedge clk);
    chk("resume_de", 32'(de), 1);
    chk("resume_x", 32'(x), 10);
    chk("resume_y", 32'(y), 1);

    // Reset mid-line with a load pending: back to defaults, pending discarded.
    set_cfg(12, 2, 4, 2, 8, 1, 2, 1);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("busy_before_rst", 32'(cfg_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0; mh = 0; mv = 0;
    clear_tally();
    run(1260, 20, 4, 6, 5, 10, 2, 3, 3);
    chk("post_rst_model", 32'(n_err), 0);
    chk("post_rst_de_count", 32'(n_de), 400);
    chk("post_rst_frame_starts", 32'(n_fs), 2);
    chk("post_rst_busy", 32'(cfg_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
